multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle MIPS core; sequences the shared ALU, register file, PC and unified memory.

---
 rtl/multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences ALU, register file, PC and
// unified memory over a req/ready handshake, halting on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       rs_eq_rt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_ctl_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       retire,
    output logic       halted,
    output logic [1:0] err_code
);

    localparam logic [3:0] S_RST     = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_EXEC_R  = 4'd3;
    localparam logic [3:0] S_WB_R    = 4'd4;
    localparam logic [3:0] S_ADDR    = 4'd5;
    localparam logic [3:0] S_ADDI_EX = 4'd6;
    localparam logic [3:0] S_ADDI_WB = 4'd7;
    localparam logic [3:0] S_MEM_RD  = 4'd8;
    localparam logic [3:0] S_WB_MEM  = 4'd9;
    localparam logic [3:0] S_MEM_WR  = 4'd10;
    localparam logic [3:0] S_BRANCH  = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;
    localparam logic [3:0] S_HALT    = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);

    logic [3:0]       state_r;
    logic [3:0]       state_s;
    logic [TMO_W-1:0] cnt_r;
    logic [TMO_W-1:0] cnt_s;
    logic [1:0]       err_r;
    logic [1:0]       err_s;
    logic             wait_s;
    logic             tmo_s;

    assign wait_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
    // Ready in the same cycle as the last allowed wait still completes the access.
    assign tmo_s  = wait_s && !mem_ready && (cnt_r == TMO_LIM);

    // Next-state, wait-counter and sticky error computation.
    always_comb begin
        state_s = state_r;
        err_s   = err_r;
        cnt_s   = {TMO_W{1'b0}};
        if (wait_s && !mem_ready && !tmo_s) begin
            cnt_s = cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = {TMO_W{1'b0}};
        end
        case (state_r)
            S_RST:     state_s = S_FETCH;
            S_FETCH: begin
                if (tmo_s) begin
                    state_s = S_HALT;
                    err_s   = 2'b10;
                end else if (mem_ready) begin
                    state_s = S_DECODE;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_s = S_EXEC_R;
                    OP_LW, OP_SW: state_s = S_ADDR;
                    OP_ADDI:      state_s = S_ADDI_EX;
                    OP_BEQ:       state_s = S_BRANCH;
                    OP_J:         state_s = S_JUMP;
                    default: begin
                        state_s = S_HALT;
                        err_s   = 2'b01;
                    end
                endcase
            end
            S_EXEC_R: begin
                if ((opcode == OP_RTYPE) && (funct == 6'd0)) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_WB_R;
                end
            end
            S_WB_R:    state_s = S_FETCH;
            S_ADDR: begin
                if (opcode == OP_LW) begin
                    state_s = S_MEM_RD;
                end else begin
                    state_s = S_MEM_WR;
                end
            end
            S_ADDI_EX: state_s = S_ADDI_WB;
            S_ADDI_WB: state_s = S_FETCH;
            S_MEM_RD, S_MEM_WR: begin
                if (tmo_s) begin
                    state_s = S_HALT;
                    err_s   = 2'b10;
                end else if (mem_ready) begin
                    state_s = (state_r == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else begin
                    state_s = state_r;
                end
            end
            S_WB_MEM:  state_s = S_FETCH;
            S_BRANCH:  state_s = S_FETCH;
            S_JUMP:    state_s = S_FETCH;
            S_HALT:    state_s = S_HALT;
            default: begin
                state_s = S_HALT;
                err_s   = err_r;
            end
        endcase
    end

    // State, wait counter and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_RST;
            cnt_r   <= {TMO_W{1'b0}};
            err_r   <= 2'b00;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
        end
    end

    // Datapath controls decoded from the registered state; memory strobes gated by ready.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctl_op = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b01;
                alu_ctl_op = 1'b1;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                alu_ctl_op = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                retire    = (opcode == OP_RTYPE) && (funct == 6'd0);
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_ADDR, S_ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_ctl_op = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_WB_MEM: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                retire  = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_source = 2'b01;
                pc_write  = rs_eq_rt;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign err_code = err_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a random instruction
// stream, each cycle compared against a per-instruction behavioural model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_ctl_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       retire;
        logic       halted;
        logic [1:0] err_code;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       rs_eq_rt = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_ctl_op, reg_dst, mem_to_reg, reg_write, retire, halted;
    logic [1:0] err_code;
    outs_t      obs;

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] exp_err = 2'b00;
    bit         in_halt = 1'b0;

    multicycle_ctrl #(.TMO_W(4), .TMO_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rs_eq_rt(rs_eq_rt),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl_op(alu_ctl_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .retire(retire), .halted(halted), .err_code(err_code)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_source, alu_src_a, alu_src_b,
                  alu_ctl_op, reg_dst, mem_to_reg, reg_write, retire, halted, err_code};

    function automatic outs_t z();
        outs_t o;
        o = '0;
        o.err_code = exp_err;
        return o;
    endfunction

    task automatic check(input string tag, input outs_t e);
        n_vec++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic cyc(input string tag, input outs_t e);
        @(negedge clk);
        check(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_err = 2'b00;
        in_halt = 1'b0;
        check("rst_async", z());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        cyc("rst_state", z());
    endtask

    task automatic halt_check(input int n);
        outs_t e;
        in_halt = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            e = z();
            e.halted = 1'b1;
            cyc("halt", e);
        end
    endtask

    // One memory access: ready arrives after `delay` wait cycles; 16 or more waits time out.
    task automatic mem_phase(input string tag, input outs_t base, input outs_t on_rdy,
                             input int delay, output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 16 && !ok; w++) begin
            mem_ready = (w == delay);
            cyc(tag, mem_ready ? on_rdy : base);
            ok = (w == delay);
        end
        if (!ok) exp_err = 2'b10;
    endtask

    task automatic exec(input logic [5:0] op, input logic [5:0] fn, input bit eq,
                        input int dfetch, input int dmem);
        outs_t e, r;
        bit    ok;
        opcode = op;
        funct = fn;
        rs_eq_rt = 1'($urandom);
        e = z(); e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.alu_ctl_op = 1'b1;
        r = e; r.ir_write = 1'b1; r.pc_write = 1'b1;
        mem_phase("fetch", e, r, dfetch, ok);
        if (!ok) begin
            halt_check(3);
            return;
        end
        mem_ready = 1'($urandom);
        e = z(); e.alu_src_b = 2'b11; e.alu_ctl_op = 1'b1;
        cyc("decode", e);
        mem_ready = 1'($urandom);
        case (op)
            6'd0: begin
                e = z(); e.alu_src_a = 1'b1; e.retire = (fn == 6'd0);
                cyc("exec_r", e);
                if (fn != 6'd0) begin
                    e = z(); e.reg_dst = 1'b1; e.reg_write = 1'b1; e.retire = 1'b1;
                    cyc("wb_r", e);
                end
            end
            6'd35, 6'd43: begin
                e = z(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctl_op = 1'b1;
                cyc("addr", e);
                e = z(); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (op == 6'd43);
                r = e; r.retire = (op == 6'd43);
                mem_phase(op == 6'd35 ? "mem_rd" : "mem_wr", e, r, dmem, ok);
                if (!ok) begin
                    halt_check(3);
                end else if (op == 6'd35) begin
                    mem_ready = 1'($urandom);
                    e = z(); e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.retire = 1'b1;
                    cyc("wb_mem", e);
                end
            end
            6'd8: begin
                e = z(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctl_op = 1'b1;
                cyc("addi_ex", e);
                e = z(); e.reg_write = 1'b1; e.retire = 1'b1;
                cyc("addi_wb", e);
            end
            6'd4: begin
                rs_eq_rt = eq;
                e = z(); e.alu_src_a = 1'b1; e.pc_source = 2'b01; e.pc_write = eq; e.retire = 1'b1;
                cyc("branch", e);
            end
            6'd2: begin
                e = z(); e.pc_source = 2'b10; e.pc_write = 1'b1; e.retire = 1'b1;
                cyc("jump", e);
            end
            default: begin
                exp_err = 2'b01;
                halt_check(3);
            end
        endcase
    endtask

    // Store that is cut short by reset while waiting on memory.
    task automatic sw_abort();
        outs_t e;
        exec(6'd2, 6'd0, 1'b0, 0, 0);
        opcode = 6'd43;
        mem_ready = 1'b1;
        cyc("fetch_sw", '{mem_req: 1'b1, alu_src_b: 2'b01, alu_ctl_op: 1'b1, ir_write: 1'b1,
                          pc_write: 1'b1, default: '0});
        mem_ready = 1'b0;
        e = z(); e.alu_src_b = 2'b11; e.alu_ctl_op = 1'b1;
        cyc("decode_sw", e);
        e = z(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctl_op = 1'b1;
        cyc("addr_sw", e);
        @(negedge clk);
        e = z(); e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
        check("mem_wr_pre", e);
        #2;
        do_reset();
    endtask

    initial begin
        logic [5:0] legal [6];
        logic [5:0] op;
        int         k;
        bit         is_legal;
        legal = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd4, 6'd2};
        #2;
        do_reset();
        exec(6'd0, 6'b100000, 1'b0, 0, 0);
        exec(6'd35, 6'd0, 1'b0, 0, 3);
        exec(6'd4, 6'd0, 1'b1, 0, 0);
        exec(6'd4, 6'd0, 1'b0, 0, 0);
        exec(6'b111111, 6'd0, 1'b0, 0, 0);
        halt_check(17);
        do_reset();
        exec(6'd0, 6'b100000, 1'b0, 16, 0);
        do_reset();
        exec(6'd0, 6'b100000, 1'b0, 15, 0);
        exec(6'd43, 6'd0, 1'b0, 2, 16);
        do_reset();
        exec(6'd0, 6'd0, 1'b0, 1, 0);
        exec(6'd8, 6'd0, 1'b0, 0, 0);
        exec(6'd43, 6'd0, 1'b0, 0, 15);
        sw_abort();
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 19);
            if (k < 18) begin
                op = legal[k % 6];
            end else begin
                is_legal = 1'b1;
                op = 6'd0;
                while (is_legal) begin
                    op = 6'($urandom);
                    is_legal = 1'b0;
                    for (int j = 0; j < 6; j++) if (legal[j] == op) is_legal = 1'b1;
                end
            end
            exec(op, ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom), 1'($urandom),
                 ($urandom_range(0, 24) == 0) ? 16 : $urandom_range(0, 3),
                 ($urandom_range(0, 24) == 0) ? 16 : $urandom_range(0, 3));
            if (in_halt) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
